// File: rtl/pattern_detect.sv
// Serial bit-pattern detector with configurable length and overlap mode.
// Ports: clk, rst (sync active-low), in_valid/in serial stream,
//    cfg_load/cfg_pattern/cfg_len/cfg_overlap config load, cnt_clr,
//    match (1-cycle pulse), match_cnt (saturating), cfg_err.
module pattern_detect #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W = 8,
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [LW-1:0]    FULL = LW'(MAX_LEN);
   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

   logic [0:0]         state;
   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic               ovl;
   logic [MAX_LEN-1:0] hist;
   logic [LW-1:0]      fill;

   logic [MAX_LEN-1:0] hist_n;
   logic [MAX_LEN-1:0] mask;
   logic [LW-1:0]      fill_n;
   logic               accept;
   logic               hit;
   logic               len_ok;

   // Only the low len bits of history take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (LW'(i) < len);
   end

   always_comb begin
      hist_n = {hist[MAX_LEN-2:0], in};
      fill_n = (fill == FULL) ? fill : fill + LW'(1);
      // A load edge discards the serial bit.
      accept = (state == RUN) && in_valid && !cfg_load;
      hit    = accept && (fill_n >= len) &&
               (((hist_n ^ pat) & mask) == '0);
      len_ok = (cfg_len != '0) && (cfg_len <= FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pat       <= '0;
         len       <= '0;
         ovl       <= 1'b0;
         hist      <= '0;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         cfg_err   <= 1'b0;
      end else begin
         match <= hit;

         if (cnt_clr)
            match_cnt <= hit ? CNT_W'(1) : '0;
         else if (hit && match_cnt != CMAX)
            match_cnt <= match_cnt + CNT_W'(1);

         if (cfg_load) begin
            if (len_ok) begin
               pat     <= cfg_pattern;
               len     <= cfg_len;
               ovl     <= cfg_overlap;
               hist    <= '0;
               fill    <= '0;
               cfg_err <= 1'b0;
               state   <= RUN;
            end else begin
               cfg_err <= 1'b1;
               state   <= IDLE;
            end
         end else if (accept) begin
            hist <= hist_n;
            // Non-overlap: next match must be built from fresh bits.
            fill <= (hit && !ovl) ? '0 : fill_n;
         end
      end
   end

endmodule

// File: tb/tb_pattern_detect.sv
// Directed self-checking bench for pattern_detect.
// A second instance with CNT_W=2 shares all inputs to check saturation.
module tb_pattern_detect;

   localparam int ML = 8;
   localparam int LW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in = 1'b0;
   logic          cfg_load = 1'b0;
   logic [ML-1:0] cfg_pattern = '0;
   logic [LW-1:0] cfg_len = '0;
   logic          cfg_overlap = 1'b0;
   logic          cnt_clr = 1'b0;
   logic          match, match_s;
   logic [7:0]    match_cnt;
   logic [1:0]    cnt_s;
   logic          cfg_err, err_s;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] ms;

   pattern_detect #(.MAX_LEN(ML), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cnt_clr(cnt_clr), .match(match),
      .match_cnt(match_cnt), .cfg_err(cfg_err)
   );

   pattern_detect #(.MAX_LEN(ML), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cnt_clr(cnt_clr), .match(match_s),
      .match_cnt(cnt_s), .cfg_err(err_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [ML-1:0] p, input logic [LW-1:0] l,
                       input logic o);
      cfg_load = 1'b1;
      cfg_pattern = p;
      cfg_len = l;
      cfg_overlap = o;
      in_valid = 1'b1;
      in = 1'b1;
      tick();
      cfg_load = 1'b0;
      in_valid = 1'b0;
      cfg_pattern = '0;
      cfg_len = '0;
      cfg_overlap = 1'b0;
   endtask

   task automatic clr();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   // Send n bits MSB first, with per-bit valid; returns match trace.
   task automatic send(input logic [31:0] b, input logic [31:0] v,
                       input int n, output logic [31:0] m);
      m = '0;
      for (int i = n - 1; i >= 0; i--) begin
         in_valid = v[i];
         in = b[i];
         tick();
         m = {m[30:0], match};
      end
      in_valid = 1'b0;
      in = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      tick();
      tick();
      chk("rst_match", {31'd0, match}, 32'd0);
      chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
      chk("rst_err", {31'd0, cfg_err}, 32'd0);
      rst = 1'b1;
      tick();

      send(32'b10010, 32'h1f, 5, ms);
      chk("idle_nomatch", ms, 32'd0);

      // Overlapping stream
      load(8'b10010, 4'd5, 1'b1);
      chk("load_match0", {31'd0, match}, 32'd0);
      chk("load_err0", {31'd0, cfg_err}, 32'd0);
      clr();
      send(32'b10010010, 32'hff, 8, ms);
      chk("ovl_trace", ms, 32'b00001001);
      chk("ovl_cnt", {24'd0, match_cnt}, 32'd2);

      // Non-overlapping stream
      load(8'b10010, 4'd5, 1'b0);
      clr();
      send(32'b10010010, 32'hff, 8, ms);
      chk("novl_trace", ms, 32'b00001000);
      chk("novl_cnt", {24'd0, match_cnt}, 32'd1);

      // Bubbles do not break the sequence
      load(8'b10010, 4'd5, 1'b1);
      clr();
      send(32'b10000010, 32'b11000111, 8, ms);
      chk("bubble_trace", ms, 32'b00000001);
      chk("bubble_cnt", {24'd0, match_cnt}, 32'd1);

      // Saturation and clear on a match edge
      load(8'b11, 4'd2, 1'b1);
      clr();
      chk("clr_cnt", {30'd0, cnt_s}, 32'd0);
      send(32'b111111, 32'h3f, 6, ms);
      chk("sat_trace", ms, 32'b011111);
      chk("sat_cnt", {30'd0, cnt_s}, 32'd3);
      chk("wide_cnt", {24'd0, match_cnt}, 32'd5);
      cnt_clr = 1'b1;
      in_valid = 1'b1;
      in = 1'b1;
      tick();
      cnt_clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_hit_match", {31'd0, match_s}, 32'd1);
      chk("clr_hit_cnt", {30'd0, cnt_s}, 32'd1);

      // Illegal lengths
      load(8'b10010, 4'd0, 1'b1);
      chk("len0_err", {31'd0, cfg_err}, 32'd1);
      send(32'b10010, 32'h1f, 5, ms);
      chk("len0_nomatch", ms, 32'd0);
      load(8'b10010, 4'd5, 1'b1);
      chk("reload_err", {31'd0, cfg_err}, 32'd0);
      load(8'b10010, 4'd9, 1'b1);
      chk("len9_err", {31'd0, cfg_err}, 32'd1);
      send(32'b10010, 32'h1f, 5, ms);
      chk("len9_nomatch", ms, 32'd0);

      // Full-width pattern
      load(8'b10110011, 4'd8, 1'b0);
      clr();
      send(32'b110110011, 32'h1ff, 9, ms);
      chk("len8_trace", ms, 32'b000000001);

      // Reset mid-sequence
      load(8'b10010, 4'd5, 1'b1);
      send(32'b1001, 32'hf, 4, ms);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_cnt", {24'd0, match_cnt}, 32'd0);
      chk("mid_rst_err", {31'd0, cfg_err}, 32'd0);
      send(32'b0, 32'h1, 1, ms);
      chk("rst_idle_nomatch", ms, 32'd0);
      load(8'b10010, 4'd5, 1'b1);
      send(32'b0, 32'h1, 1, ms);
      chk("rst_reload_nomatch", ms, 32'd0);
      chk("rst_reload_cnt", {24'd0, match_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pattern_detect.md
PATTERN_DETECT -- requirements
Module: pattern_detect

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match-counter width in bits.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have these ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies in; high means the serial bit is sampled this edge.
- in  input  1  serial data bit.
- cfg_load  input  1  loads the configuration below.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  input  $clog2(MAX_LEN+1)  active pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cnt_clr  input  1  clears match_cnt.
- match  output  1  registered one-cycle pulse per detected pattern.
- match_cnt  output  CNT_W  saturating count of matches.
- cfg_err  output  1  last load had an illegal cfg_len.

Function
REQ-005 The FSM SHALL have two states: IDLE (no detection) and RUN (detecting).
REQ-006 A cfg_load with 1 <= cfg_len <= MAX_LEN SHALL register pattern, length and overlap, clear cfg_err, clear history and fill count, and go to RUN.
REQ-007 A cfg_load with cfg_len = 0 or cfg_len > MAX_LEN SHALL set cfg_err = 1 and go to IDLE; the stored configuration is don't-care.
REQ-008 cfg_load SHALL take priority over in_valid; the in bit on a load edge SHALL be discarded, and match SHALL be 0 in the following cycle.
REQ-009 In RUN, each edge with in_valid = 1 SHALL shift in into a MAX_LEN-bit history (newest at bit 0) and increment a fill count saturating at MAX_LEN.
REQ-010 Edges with in_valid = 0 SHALL leave history and fill unchanged, so bubbles do not break a sequence.
REQ-011 A match SHALL occur on an accepting edge when fill (after update) >= len and history[len-1:0] (after update) equals pattern[len-1:0].
REQ-012 match SHALL be high for exactly the one cycle following the edge that samples the final pattern bit (latency 1); otherwise 0.
REQ-013 In overlap mode, history and fill SHALL be retained after a match.
REQ-014 In non-overlap mode, fill SHALL reset to 0 on the matching edge, so the next match needs len fresh bits.
REQ-015 In IDLE, match SHALL stay 0 and history SHALL not update.
REQ-016 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1.
REQ-017 cnt_clr SHALL clear match_cnt at the next edge; if a match occurs on the same edge, match_cnt SHALL become 1.
REQ-018 Configuration SHALL change only on cfg_load; cfg_* inputs SHALL be ignored otherwise.

Reset
REQ-019 With rst = 0 at a rising edge, the block SHALL set state IDLE, match 0, match_cnt 0, cfg_err 0, stored pattern 0, length 0, overlap 0, and history and fill 0.
REQ-020 A reset mid-sequence SHALL discard all partial history; detection resumes only after a new cfg_load.

Verification
REQ-021 Load pattern 10010, len 5, overlap 1; stream 1,0,0,1,0,0,1,0 with in_valid held high -> match pulses after bit 5 and bit 8; match_cnt = 2.
REQ-022 Same stream with overlap 0 -> single match after bit 5; match_cnt = 1.
REQ-023 Pattern 10010, overlap 1; send 1,0 then 3 cycles with in_valid = 0, then 0,1,0 -> one match after the last bit.
REQ-024 CNT_W = 2, pattern 11, len 2, overlap 1; six consecutive 1s -> 5 match pulses, match_cnt saturates at 3. Then assert cnt_clr on a match edge -> match_cnt = 1.
REQ-025 cfg_len = 0 load -> cfg_err = 1; stream 10010 -> no match. Reload with len 5 -> cfg_err = 0.
REQ-026 Pattern 10010; send 1,0,0,1, pulse rst low one cycle, reload, send 0 -> no match; match_cnt = 0.
